// File: rtl/parking_pkg.sv
// Shared definitions for the parking access controller front end:
// keypad entry state encoding, default key codes and the PIN width.
package parking_pkg;

    localparam int PIN_W = 8;

    localparam logic [3:0] KE_CLEAR_CODE = 4'hA;
    localparam logic [3:0] KE_ENTER_CODE = 4'hB;

    typedef enum logic [1:0] {
        KE_IDLE = 2'd0,
        KE_ONE  = 2'd1,
        KE_TWO  = 2'd2
    } ke_state_t;

endpackage

// File: rtl/key_edge_detect.sv
// Turns a debounced level into a one-cycle pulse on its rising edge.
// History resets high so a level already asserted at reset release is
// not mistaken for a fresh press.
module key_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic history;

    // Remember the previous level every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            history <= 1'b1;
        end else begin
            history <= level;
        end
    end

    assign pulse = level & ~history;

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: accumulates up to two decimal digits from keypad
// press events and hands a clean 0-99 value plus a one-cycle submit strobe
// to the parking access controller. Clear, inactivity timeout and
// malformed keys are absorbed here.
module keypad_code_entry
    import parking_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter logic [3:0] CLEAR_CODE     = KE_CLEAR_CODE,
    parameter logic [3:0] ENTER_CODE     = KE_ENTER_CODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_code,
    input  logic             key_press,
    output logic [PIN_W-1:0] psswrd_atmpt,
    output logic             try_psswrd,
    output logic             entry_busy,
    output logic [1:0]       digit_count,
    output logic             entry_error
);

    localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ke_state_t        state, state_nxt;
    logic [PIN_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PIN_W-1:0] atmpt, atmpt_nxt;
    logic             try_r, try_nxt;
    logic             err_r, err_nxt;
    logic             key_evt;
    logic             is_digit;
    logic [PIN_W-1:0] digit;

    key_edge_detect u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .level (key_press),
        .pulse (key_evt)
    );

    assign is_digit = (key_code <= 4'd9);
    assign digit    = {4'b0000, key_code};

    // Decode the key event (or timeout) and compute next state and outputs.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        atmpt_nxt = atmpt;
        try_nxt   = 1'b0;
        err_nxt   = 1'b0;

        if (key_evt) begin
            // Any key restarts the inactivity window; a key on the expiry
            // cycle therefore cancels the timeout.
            cnt_nxt = '0;
            if (is_digit) begin
                case (state)
                    KE_IDLE: begin
                        acc_nxt   = digit;
                        state_nxt = KE_ONE;
                    end
                    KE_ONE: begin
                        acc_nxt   = acc * 8'd10 + digit;
                        state_nxt = KE_TWO;
                    end
                    KE_TWO: begin
                        err_nxt = 1'b1;
                    end
                    default: begin
                        acc_nxt   = '0;
                        state_nxt = KE_IDLE;
                    end
                endcase
            end else if (key_code == ENTER_CODE) begin
                if (state != KE_IDLE) begin
                    atmpt_nxt = acc;
                    try_nxt   = 1'b1;
                    acc_nxt   = '0;
                    state_nxt = KE_IDLE;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (key_code == CLEAR_CODE) begin
                acc_nxt   = '0;
                state_nxt = KE_IDLE;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (state != KE_IDLE) begin
            if (cnt == CNT_LAST) begin
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = KE_IDLE;
                err_nxt   = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Register state, accumulator, timeout counter and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= KE_IDLE;
            acc   <= '0;
            cnt   <= '0;
            atmpt <= '0;
            try_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            atmpt <= atmpt_nxt;
            try_r <= try_nxt;
            err_r <= err_nxt;
        end
    end

    assign psswrd_atmpt = atmpt;
    assign try_psswrd   = try_r;
    assign entry_error  = err_r;
    assign digit_count  = state;
    assign entry_busy   = (state != KE_IDLE);

endmodule

// File: tb/tb_keypad_code_entry.sv
// Bench for keypad_code_entry: directed key sequences push expected submit
// and error pulses (with the cycle they must appear on) into a queue; a
// monitor pops one entry for every pulse the DUT produces.
module tb_keypad_code_entry;

    localparam int T = 8;
    localparam int K_NONE = 0;
    localparam int K_SUB  = 1;
    localparam int K_ERR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic       key_press = 1'b0;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd;
    logic       entry_busy;
    logic [1:0] digit_count;
    logic       entry_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] val;
        int         stamp;
    } exp_t;

    exp_t exp_q[$];

    keypad_code_entry #(
        .TIMEOUT_CYCLES (T),
        .CLEAR_CODE     (4'hA),
        .ENTER_CODE     (4'hB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_press    (key_press),
        .psswrd_atmpt (psswrd_atmpt),
        .try_psswrd   (try_psswrd),
        .entry_busy   (entry_busy),
        .digit_count  (digit_count),
        .entry_error  (entry_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe or error pulse must match the head of the queue.
    always @(negedge clk) begin
        if (try_psswrd || entry_error) begin
            checks++;
            if (try_psswrd && entry_error) begin
                errors++;
                $display("FAIL both_pulses: try=1 err=1 at cycle %0d, required never together", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: try=%0d err=%0d val=%0d at cycle %0d, required none",
                         try_psswrd, entry_error, psswrd_atmpt, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_err != entry_error || cyc != e.stamp ||
                    (!e.is_err && psswrd_atmpt != e.val)) begin
                    errors++;
                    $display("FAIL pulse: got err=%0d val=%0d cycle=%0d, required err=%0d val=%0d cycle=%0d",
                             entry_error, psswrd_atmpt, cyc, e.is_err, e.val, e.stamp);
                end
            end
        end
    end

    // Press a key for 'hold' cycles then release for 'gap' extra cycles.
    // An expectation of 'kind' is queued at (event edge + off).
    task automatic press(input logic [3:0] code, input int hold, input int gap,
                         input int kind, input logic [7:0] val, input int off,
                         output int stamp);
        exp_t e;
        @(negedge clk);
        key_code  = code;
        key_press = 1'b1;
        stamp     = cyc + 1;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.val    = val;
            e.stamp  = stamp + off;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk);
        key_press = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    int s;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_atmpt", psswrd_atmpt, 0);
        chk("rst_try", try_psswrd, 0);
        chk("rst_busy", entry_busy, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_err", entry_error, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8, 7, ENTER -> 87
        press(4'd8, 1, 0, K_NONE, 0, 0, s);
        chk("c87_count1", digit_count, 1);
        chk("c87_busy", entry_busy, 1);
        press(4'd7, 1, 0, K_NONE, 0, 0, s);
        chk("c87_count2", digit_count, 2);
        press(4'hB, 1, 0, K_SUB, 8'd87, 0, s);
        chk("c87_count0", digit_count, 0);
        chk("c87_atmpt", psswrd_atmpt, 87);
        repeat (2) @(negedge clk);

        // 5, ENTER -> 5; ENTER alone -> error, value held
        press(4'd5, 1, 0, K_NONE, 0, 0, s);
        press(4'hB, 1, 0, K_SUB, 8'd5, 0, s);
        press(4'hB, 1, 1, K_ERR, 0, 0, s);
        chk("held_atmpt", psswrd_atmpt, 5);

        // 1, 2, 3(error), ENTER -> 12
        press(4'd1, 1, 0, K_NONE, 0, 0, s);
        press(4'd2, 1, 0, K_NONE, 0, 0, s);
        press(4'd3, 1, 0, K_ERR, 0, 0, s);
        chk("third_digit_count", digit_count, 2);
        press(4'hB, 1, 0, K_SUB, 8'd12, 0, s);

        // Unused code in IDLE -> error, no state change
        press(4'hE, 1, 0, K_ERR, 0, 0, s);
        chk("unused_count", digit_count, 0);

        // Timeout: 4 then silence -> error 8 cycles after the edge
        press(4'd4, 1, 0, K_ERR, 0, T, s);
        repeat (T - 1) @(negedge clk);
        chk("pre_timeout_count", digit_count, 1);
        @(negedge clk);
        chk("timeout_count", digit_count, 0);
        chk("timeout_busy", entry_busy, 0);
        repeat (2) @(negedge clk);

        // Key landing on the expiry cycle cancels the timeout
        press(4'd4, 1, 0, K_NONE, 0, 0, s);
        repeat (T - 2) @(negedge clk);
        press(4'd6, 1, 0, K_NONE, 0, 0, s);
        chk("expiry_key_count", digit_count, 2);
        press(4'hB, 1, 0, K_SUB, 8'd46, 0, s);

        // Hold 9 for 20 cycles: one digit, then the idle timeout clears it
        press(4'd9, 20, 0, K_ERR, 0, T, s);
        chk("hold_count", digit_count, 0);
        press(4'd9, 3, 0, K_NONE, 0, 0, s);
        chk("single_press_count", digit_count, 1);
        press(4'hA, 1, 2, K_NONE, 0, 0, s);
        chk("clear_count", digit_count, 0);
        chk("clear_atmpt", psswrd_atmpt, 46);
        press(4'hA, 1, 1, K_NONE, 0, 0, s);
        chk("clear_idle_count", digit_count, 0);

        // Reset mid-entry while key 3 is still held
        @(negedge clk);
        key_code  = 4'd3;
        key_press = 1'b1;
        @(negedge clk);
        chk("pre_rst_count", digit_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_atmpt", psswrd_atmpt, 0);
        chk("mid_rst_count", digit_count, 0);
        chk("mid_rst_busy", entry_busy, 0);
        repeat (3) @(negedge clk);
        chk("held_after_rst_count", digit_count, 0);
        key_press = 1'b0;
        @(negedge clk);
        press(4'd8, 1, 0, K_NONE, 0, 0, s);
        press(4'd7, 1, 0, K_NONE, 0, 0, s);
        press(4'hB, 1, 0, K_SUB, 8'd87, 0, s);
        chk("post_rst_atmpt", psswrd_atmpt, 87);

        repeat (T + 4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
